// File: rtl/jam_cost_arbiter.sv
// rtl/jam_cost_arbiter.sv - burst round-robin arbiter sharing the cost-lookup port (optional stats: JAM_ARB_STATS_EN)
module jam_cost_arbiter #(
    parameter int BURST_LEN = 8,
    parameter int DW        = 7
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          m0_req,
    input  logic          m0_last,
    input  logic [2:0]    m0_w,
    input  logic [2:0]    m0_j,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_last,
    input  logic [2:0]    m1_w,
    input  logic [2:0]    m1_j,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic [2:0]    W,
    output logic [2:0]    J,
    input  logic [DW-1:0] Cost,
    output logic [1:0]    owner,
    output logic [15:0]   gnt_cnt0,
    output logic [15:0]   gnt_cnt1
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(BURST_LEN - 1);

    state_t     state;
    logic       prio;
    logic [3:0] beat_cnt;

    logic beat0;
    logic beat1;
    logic cur_req;
    logic cur_last;
    logic other_req;
    logic burst_end;

    // Grants and owner are decoded straight from the state register
    assign m0_gnt = (state == OWN0);
    assign m1_gnt = (state == OWN1);
    assign owner  = state;

    // Beat qualification and burst-end detection for the current owner
    always_comb begin
        beat0     = (state == OWN0) && m0_req;
        beat1     = (state == OWN1) && m1_req;
        cur_req   = 1'b0;
        cur_last  = 1'b0;
        other_req = 1'b0;
        if (state == OWN0) begin
            cur_req   = m0_req;
            cur_last  = m0_last;
            other_req = m1_req;
        end else if (state == OWN1) begin
            cur_req   = m1_req;
            cur_last  = m1_last;
            other_req = m0_req;
        end
        // A dropped request ends the burst without a beat
        burst_end = (state != IDLE) &&
                    (!cur_req || cur_last || (beat_cnt == LAST_CNT));
    end

    // Address mux: only a live beat drives the memory address, otherwise zero
    always_comb begin
        W = 3'd0;
        J = 3'd0;
        if (beat0) begin
            W = m0_w;
            J = m0_j;
        end else if (beat1) begin
            W = m1_w;
            J = m1_j;
        end
    end

    // Arbitration FSM: idle arbitration, burst tracking, hand-over without bubble
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            prio     <= 1'b0;
            beat_cnt <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    beat_cnt <= 4'd0;
                    if (m0_req && m1_req) begin
                        state <= prio ? OWN1 : OWN0;
                    end else if (m0_req) begin
                        state <= OWN0;
                    end else if (m1_req) begin
                        state <= OWN1;
                    end
                end
                OWN0, OWN1: begin
                    if (burst_end) begin
                        // Pointer moves to the other side regardless of who wins next
                        prio     <= (state == OWN0);
                        beat_cnt <= 4'd0;
                        if (other_req) begin
                            state <= (state == OWN0) ? OWN1 : OWN0;
                        end else begin
                            // Same requester re-arbitrates (or gets its bubble) via IDLE
                            state <= IDLE;
                        end
                    end else begin
                        beat_cnt <= beat_cnt + 4'd1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    beat_cnt <= 4'd0;
                end
            endcase
        end
    end

    // Read return: capture Cost on each beat, rdata holds between beats
    always_ff @(posedge CLK) begin
        if (RST) begin
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            m0_rvalid <= beat0;
            m1_rvalid <= beat1;
            if (beat0) begin
                m0_rdata <= Cost;
            end
            if (beat1) begin
                m1_rdata <= Cost;
            end
        end
    end

`ifdef JAM_ARB_STATS_EN
    // Saturating per-requester beat counters, cleared only by reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            gnt_cnt0 <= 16'd0;
            gnt_cnt1 <= 16'd0;
        end else begin
            if (beat0 && (gnt_cnt0 != 16'hFFFF)) begin
                gnt_cnt0 <= gnt_cnt0 + 16'd1;
            end
            if (beat1 && (gnt_cnt1 != 16'hFFFF)) begin
                gnt_cnt1 <= gnt_cnt1 + 16'd1;
            end
        end
    end
`else
    assign gnt_cnt0 = 16'd0;
    assign gnt_cnt1 = 16'd0;
`endif

endmodule

// File: tb/tb_jam_cost_arbiter.sv
// tb/tb_jam_cost_arbiter.sv - directed self-checking bench for jam_cost_arbiter
module tb_jam_cost_arbiter;

    localparam int DW = 7;

    logic          CLK;
    logic          RST;
    logic          m0_req, m0_last, m1_req, m1_last;
    logic [2:0]    m0_w, m0_j, m1_w, m1_j;
    logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic [2:0]    W, J;
    logic [DW-1:0] Cost;
    logic [1:0]    owner;
    logic [15:0]   gnt_cnt0, gnt_cnt1;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef JAM_ARB_STATS_EN
    localparam int EXP_CNT0 = 24;
    localparam int EXP_CNT1 = 8;
`else
    localparam int EXP_CNT0 = 0;
    localparam int EXP_CNT1 = 0;
`endif

    jam_cost_arbiter #(.BURST_LEN(8), .DW(DW)) dut (
        .CLK(CLK), .RST(RST),
        .m0_req(m0_req), .m0_last(m0_last), .m0_w(m0_w), .m0_j(m0_j),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_last(m1_last), .m1_w(m1_w), .m1_j(m1_j),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .W(W), .J(J), .Cost(Cost), .owner(owner),
        .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
    );

    // Cost memory model
    always_comb Cost = 7'(8 * W + J);

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        RST = 1'b1;
        m0_req = 0; m0_last = 0; m0_w = 0; m0_j = 0;
        m1_req = 0; m1_last = 0; m1_w = 0; m1_j = 0;
        cyc(); cyc();
        RST = 1'b0;

        // reset state
        chk("rst_owner", 32'(owner), 0);
        chk("rst_m0_gnt", 32'(m0_gnt), 0);
        chk("rst_m1_gnt", 32'(m1_gnt), 0);
        chk("rst_m0_rvalid", 32'(m0_rvalid), 0);
        chk("rst_m1_rvalid", 32'(m1_rvalid), 0);
        chk("rst_m0_rdata", 32'(m0_rdata), 0);
        chk("rst_W", 32'(W), 0);
        chk("rst_J", 32'(J), 0);
        chk("rst_cnt0", 32'(gnt_cnt0), 0);

        // m0-only 8-beat burst, last on the 8th beat
        m0_req = 1; m0_w = 0; m0_j = 7;
        #1 chk("t1_no_comb_gnt", 32'(m0_gnt), 0);
        cyc();
        chk("t1_gnt", 32'(m0_gnt), 1);
        for (int i = 0; i < 8; i++) begin
            m0_w = 3'(i); m0_j = 3'(7 - i); m0_last = (i == 7);
            #1;
            chk("t1_W", 32'(W), i);
            chk("t1_J", 32'(J), 7 - i);
            cyc();
            chk("t1_rvalid", 32'(m0_rvalid), 1);
            chk("t1_rdata", 32'(m0_rdata), 7 * i + 7);
        end
        m0_req = 0; m0_last = 0;
        #1 chk("t1_idle_owner", 32'(owner), 0);
        chk("t1_idle_W", 32'(W), 0);
        cyc();
        chk("t1_rvalid_off", 32'(m0_rvalid), 0);
        chk("t1_rdata_hold", 32'(m0_rdata), 56);

        // simultaneous request out of reset: m0 first, m1 with no bubble
        RST = 1; cyc(); RST = 0;
        m0_req = 1; m1_req = 1; m0_w = 1; m0_j = 1;
        cyc();
        chk("t2_m0_first", 32'(owner), 1);
        cyc();
        m0_last = 1;
        cyc();
        chk("t2_m1_gnt", 32'(m1_gnt), 1);
        chk("t2_m0_gnt_off", 32'(m0_gnt), 0);
        chk("t2_m0_rvalid", 32'(m0_rvalid), 1);
        chk("t2_m0_rdata", 32'(m0_rdata), 9);
        m0_req = 0; m0_last = 0; m1_w = 3; m1_j = 4; m1_last = 1;
        #1 chk("t2_W", 32'(W), 3);
        chk("t2_J", 32'(J), 4);
        cyc();
        chk("t2_m1_rvalid", 32'(m1_rvalid), 1);
        chk("t2_m1_rdata", 32'(m1_rdata), 28);
        chk("t2_idle", 32'(owner), 0);
        m1_last = 0; m0_req = 1;
        cyc();
        chk("t2_prio_back_m0", 32'(owner), 1);
        m0_req = 0;
        cyc();
        chk("t2_drop_handover", 32'(owner), 2);

        // m1 holds req without last; m0 asks at beat 3; forced off after 8 beats
        for (int i = 0; i < 8; i++) begin
            m1_w = 3'(i); m1_j = 0;
            if (i == 3) m0_req = 1;
            cyc();
            chk("t3_rvalid", 32'(m1_rvalid), 1);
            chk("t3_rdata", 32'(m1_rdata), 8 * i);
            chk("t3_owner", 32'(owner), (i == 7) ? 1 : 2);
        end
        chk("t3_m1_gnt_off", 32'(m1_gnt), 0);

        // m0 drops req after 3 beats with m1 idle
        m1_req = 0;
        for (int i = 0; i < 3; i++) begin
            m0_w = 3'(i); m0_j = 2;
            cyc();
            chk("t4_rvalid", 32'(m0_rvalid), 1);
            chk("t4_rdata", 32'(m0_rdata), 8 * i + 2);
        end
        m0_req = 0;
        #1 chk("t4_W_nobeat", 32'(W), 0);
        cyc();
        chk("t4_rvalid_off", 32'(m0_rvalid), 0);
        chk("t4_owner", 32'(owner), 0);
        chk("t4_W", 32'(W), 0);
        chk("t4_J", 32'(J), 0);

        // reset during beat 5 of an m0 burst
        m0_req = 1; m0_w = 5; m0_j = 5;
        cyc();
        for (int i = 0; i < 4; i++) cyc();
        RST = 1;
        cyc();
        chk("t5_gnt", 32'(m0_gnt), 0);
        chk("t5_rvalid", 32'(m0_rvalid), 0);
        chk("t5_owner", 32'(owner), 0);
        chk("t5_rdata", 32'(m0_rdata), 0);
        chk("t5_cnt0", 32'(gnt_cnt0), 0);
        RST = 0; m0_req = 0; m1_req = 1; m1_w = 2; m1_j = 5; m1_last = 1;
        cyc();
        chk("t5_m1_gnt", 32'(m1_gnt), 1);
        #1 chk("t5_W", 32'(W), 2);
        chk("t5_J", 32'(J), 5);
        cyc();
        chk("t5_m1_rvalid", 32'(m1_rvalid), 1);
        chk("t5_m1_rdata", 32'(m1_rdata), 21);
        chk("t5_idle", 32'(owner), 0);
        m1_req = 0; m1_last = 0;

        // three forced m0 bursts (bubble between) then one m1 burst
        RST = 1; cyc(); RST = 0;
        m0_req = 1; m0_last = 0; m0_w = 1; m0_j = 1;
        for (int k = 1; k <= 27; k++) begin
            cyc();
            if (k == 9 || k == 18) chk("t6_bubble", 32'(owner), 0);
            if (k == 10) chk("t6_regrant", 32'(owner), 1);
        end
        chk("t6_end_m0", 32'(owner), 0);
        m0_req = 0; m1_req = 1;
        cyc();
        chk("t6_m1_gnt", 32'(owner), 2);
        for (int k = 0; k < 8; k++) cyc();
        m1_req = 0;
        chk("t6_end_m1", 32'(owner), 0);
        chk("t6_cnt0", 32'(gnt_cnt0), EXP_CNT0);
        chk("t6_cnt1", 32'(gnt_cnt1), EXP_CNT1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
